// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI initiator: FSM encoding, mode codes
// and a ceiling-log2 used to size counters from parameters.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // SPI mode codes as {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Minimum result is 1 so a counter is never zero bits wide.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result = result + 1;
    if (result == 0) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/spi_master_xfer_if.sv
// Host-side request/response signals plus the SPI pins of the initiator.
interface spi_master_xfer_if #(
  parameter int DATA_WIDTH = 8
);
  // Handshake: i_start is a request that is taken only on an edge where
  // o_busy is low (i_tx_data is captured on that same edge); o_busy then stays
  // high until the cycle in which o_done pulses for exactly one clk, carrying
  // the received word on o_rx_data. Requests made while busy are dropped.
  logic                  i_start;
  logic [DATA_WIDTH-1:0] i_tx_data;
  logic                  o_busy;
  logic                  o_done;
  logic [DATA_WIDTH-1:0] o_rx_data;
  logic                  o_sclk;
  logic                  o_cs_n;
  logic                  o_mosi;
  logic                  i_miso;

  modport master (
    input  i_start, i_tx_data, i_miso,
    output o_busy, o_done, o_rx_data, o_sclk, o_cs_n, o_mosi
  );

  modport slave (
    output i_start, i_tx_data, i_miso,
    input  o_busy, o_done, o_rx_data, o_sclk, o_cs_n, o_mosi
  );
endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period counter, edge counter and the SCLK flop.
// Edge strobes are asserted in the cycle whose closing clk edge toggles SCLK.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter logic CPOL                  = 1'b0,
  parameter int   HALF_CLK_PERIOD       = 100,
  parameter int   HALF_CLK_PERIOD_WIDTH = 7,
  parameter int   DATA_WIDTH            = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic sclk,
  output logic lead_edge,
  output logic trail_edge,
  output logic last_edge
);

  localparam int EDGES = 2 * DATA_WIDTH;
  localparam int EW    = clog2(EDGES);
  localparam int HCW   = HALF_CLK_PERIOD_WIDTH;

  logic [HCW-1:0] half_cnt;
  logic [EW-1:0]  edge_cnt;
  logic           wrap;

  assign wrap       = enable && (half_cnt == HCW'(HALF_CLK_PERIOD - 1));
  // edge_cnt counts toggles already made, so an even count means the next one is odd (leading)
  assign lead_edge  = wrap && !edge_cnt[0];
  assign trail_edge = wrap &&  edge_cnt[0];
  assign last_edge  = wrap && (edge_cnt == EW'(EDGES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt <= '0;
      edge_cnt <= '0;
      sclk     <= CPOL;
    end else if (!enable) begin
      half_cnt <= '0;
      edge_cnt <= '0;
      sclk     <= CPOL;
    end else if (wrap) begin
      half_cnt <= '0;
      sclk     <= ~sclk;
      edge_cnt <= last_edge ? '0 : edge_cnt + 1'b1;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_xfer.sv
// SPI initiator: one DATA_WIDTH-bit full-duplex MSB-first transfer per accepted
// start, CS framed by setup/hold gaps, any of the four CPOL/CPHA modes.
module spi_master_xfer
  import spi_pkg::*;
#(
  parameter logic CPOL                  = 1'b0,
  parameter logic CPHA                  = 1'b0,
  parameter int   HALF_CLK_PERIOD       = 100,
  parameter int   HALF_CLK_PERIOD_WIDTH = 7,
  parameter int   DATA_WIDTH            = 8,
  parameter int   CS_SETUP              = 4,
  parameter int   CS_HOLD               = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_master_xfer_if.master   bus,
  output state_t              o_state
);

  localparam logic [1:0] SPI_MODE   = {CPOL, CPHA};
  localparam bit         SHIFT_LEAD = (SPI_MODE == MODE1) || (SPI_MODE == MODE3);
  localparam int         PHASE_MAX  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int         PW         = clog2(PHASE_MAX);

  state_t                state;
  logic [PW-1:0]         phase_cnt;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic [DATA_WIDTH-1:0] rx_sh;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  cs_n_q;
  logic                  mosi_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  sclk;
  logic                  lead_edge;
  logic                  trail_edge;
  logic                  last_edge;
  logic                  shift_now;
  logic                  sample_now;

  spi_sclk_gen #(
    .CPOL                  (CPOL),
    .HALF_CLK_PERIOD       (HALF_CLK_PERIOD),
    .HALF_CLK_PERIOD_WIDTH (HALF_CLK_PERIOD_WIDTH),
    .DATA_WIDTH            (DATA_WIDTH)
  ) u_sclk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (state == XFER),
    .sclk       (sclk),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .last_edge  (last_edge)
  );

  // With CPHA=0 the MSB is already on MOSI before the first edge, so the final trailing edge must not shift.
  assign shift_now  = SHIFT_LEAD ? lead_edge  : (trail_edge && !last_edge);
  assign sample_now = SHIFT_LEAD ? trail_edge : lead_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase_cnt <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      rx_data_q <= '0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            tx_sh     <= SHIFT_LEAD ? bus.i_tx_data : {bus.i_tx_data[DATA_WIDTH-2:0], 1'b0};
            mosi_q    <= SHIFT_LEAD ? 1'b0 : bus.i_tx_data[DATA_WIDTH-1];
            cs_n_q    <= 1'b0;
            busy_q    <= 1'b1;
            phase_cnt <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (phase_cnt == PW'(CS_SETUP - 1)) begin
            phase_cnt <= '0;
            state     <= XFER;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        XFER: begin
          if (shift_now) begin
            mosi_q <= tx_sh[DATA_WIDTH-1];
            tx_sh  <= {tx_sh[DATA_WIDTH-2:0], 1'b0};
          end
          if (sample_now) rx_sh <= {rx_sh[DATA_WIDTH-2:0], bus.i_miso};
          if (last_edge) state <= HOLD;
        end
        HOLD: begin
          if (phase_cnt == PW'(CS_HOLD - 1)) begin
            phase_cnt <= '0;
            cs_n_q    <= 1'b1;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            rx_data_q <= rx_sh;
            mosi_q    <= 1'b0;
            state     <= IDLE;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_sclk    = sclk;
  assign bus.o_cs_n    = cs_n_q;
  assign bus.o_mosi    = mosi_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_done    = done_q;
  assign bus.o_rx_data = rx_data_q;
  assign o_state       = state;

endmodule

// File: tb/tb_spi_master_xfer.sv
// Bench for spi_master_xfer: a mode-0 loopback instance, three instances in
// modes 1-3 talking to a small slave model, and a 16-bit fast-SCLK loopback.
module tb_spi_master_xfer;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst0_n;
  logic rstm_n;
  int   total;
  int   bad;

  always #5 clk = ~clk;

  // Mode 0, HALF=4, 8 bits, setup/hold 2, MISO looped back to MOSI
  spi_master_xfer_if #(.DATA_WIDTH(8)) bus0 ();
  state_t state0;
  assign bus0.i_miso = bus0.o_mosi;

  spi_master_xfer #(
    .CPOL(1'b0), .CPHA(1'b0), .HALF_CLK_PERIOD(4), .HALF_CLK_PERIOD_WIDTH(2),
    .DATA_WIDTH(8), .CS_SETUP(2), .CS_HOLD(2)
  ) u_mode0 (
    .clk(clk), .rst_n(rst0_n), .bus(bus0), .o_state(state0)
  );

  // Mode 0, HALF=2, 16 bits, loopback
  spi_master_xfer_if #(.DATA_WIDTH(16)) bus4 ();
  state_t state4;
  assign bus4.i_miso = bus4.o_mosi;

  spi_master_xfer #(
    .CPOL(1'b0), .CPHA(1'b0), .HALF_CLK_PERIOD(2), .HALF_CLK_PERIOD_WIDTH(1),
    .DATA_WIDTH(16), .CS_SETUP(2), .CS_HOLD(2)
  ) u_wide (
    .clk(clk), .rst_n(rstm_n), .bus(bus4), .o_state(state4)
  );

  // Modes 1..3 against a slave that answers 0x3C and records MOSI
  logic       m_start [1:3];
  logic [7:0] m_tx    [1:3];
  logic       m_done  [1:3];
  logic       m_sclk  [1:3];
  logic       m_cs_n  [1:3];
  logic       m_busy  [1:3];
  logic [7:0] m_rx    [1:3];
  logic [7:0] m_rec   [1:3];
  state_t     m_state [1:3];
  logic [7:0] slave_word;
  assign slave_word = 8'h3C;

  for (genvar g = 1; g <= 3; g++) begin : g_mode
    localparam logic GPOL = (g >= 2) ? 1'b1 : 1'b0;
    localparam logic GPHA = (g % 2 == 1) ? 1'b1 : 1'b0;

    spi_master_xfer_if #(.DATA_WIDTH(8)) mb ();
    state_t     st;
    logic       sclk_d;
    logic       cs_d;
    logic       miso_q;
    logic [7:0] rec;
    int         idx;

    assign mb.i_start   = m_start[g];
    assign mb.i_tx_data = m_tx[g];
    assign mb.i_miso    = miso_q;
    assign m_done[g]    = mb.o_done;
    assign m_sclk[g]    = mb.o_sclk;
    assign m_cs_n[g]    = mb.o_cs_n;
    assign m_busy[g]    = mb.o_busy;
    assign m_rx[g]      = mb.o_rx_data;
    assign m_rec[g]     = rec;
    assign m_state[g]   = st;

    spi_master_xfer #(
      .CPOL(GPOL), .CPHA(GPHA), .HALF_CLK_PERIOD(4), .HALF_CLK_PERIOD_WIDTH(2),
      .DATA_WIDTH(8), .CS_SETUP(2), .CS_HOLD(2)
    ) u_dut (
      .clk(clk), .rst_n(rstm_n), .bus(mb), .o_state(st)
    );

    // Slave reacts one clk after it sees an SCLK edge; ample margin at HALF=4.
    always @(posedge clk or negedge rstm_n) begin
      if (!rstm_n) begin
        sclk_d <= GPOL;
        cs_d   <= 1'b1;
        miso_q <= 1'b0;
        rec    <= 8'h00;
        idx    <= 7;
      end else begin
        sclk_d <= mb.o_sclk;
        cs_d   <= mb.o_cs_n;
        if (mb.o_cs_n) begin
          if (GPHA) begin
            idx <= 7;
          end else begin
            idx    <= 6;
            miso_q <= slave_word[7];
          end
        end else if (cs_d) begin
          rec <= 8'h00;
        end else if (mb.o_sclk != sclk_d) begin
          if ((sclk_d == GPOL) != GPHA) begin
            rec <= {rec[6:0], mb.o_mosi};
          end else if (idx >= 0) begin
            miso_q <= slave_word[3'(idx)];
            idx    <= idx - 1;
          end
        end
      end
    end
  end

  task automatic run0(input logic [7:0] tx, input int poke_at, output logic [7:0] rx,
                      output int cs_low, output int toggles, output int dones,
                      output bit timed_out);
    logic prev_sclk;
    int   after;
    @(negedge clk);
    bus0.i_tx_data = tx;
    bus0.i_start   = 1'b1;
    prev_sclk = bus0.o_sclk;
    cs_low = 0; toggles = 0; dones = 0; rx = 8'h00; timed_out = 1'b1; after = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (cyc == 0) bus0.i_start = 1'b0;
      if (poke_at > 0 && cyc == poke_at) begin
        bus0.i_start   = 1'b1;
        bus0.i_tx_data = 8'hFF;
      end else if (poke_at > 0 && cyc == poke_at + 1) begin
        bus0.i_start   = 1'b0;
        bus0.i_tx_data = tx;
      end
      if (!bus0.o_cs_n) cs_low++;
      if (bus0.o_sclk !== prev_sclk) toggles++;
      prev_sclk = bus0.o_sclk;
      if (bus0.o_done) begin
        dones++;
        rx = bus0.o_rx_data;
      end
      if (dones > 0) begin
        after++;
        if (after > 8) begin
          timed_out = 1'b0;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    total++; if (bus0.o_cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n got=%b exp=1", bus0.o_cs_n); end
    total++; if (bus0.o_sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk got=%b exp=0", bus0.o_sclk); end
    total++; if (bus0.o_mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b exp=0", bus0.o_mosi); end
    total++; if (bus0.o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus0.o_busy); end
    total++; if (bus0.o_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus0.o_done); end
    total++; if (bus0.o_rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx got=%h exp=00", bus0.o_rx_data); end
    total++; if (state0 !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", state0, IDLE); end
    for (int m = 1; m <= 3; m++) begin
      total++;
      if (m_sclk[m] !== ((m >= 2) ? 1'b1 : 1'b0)) begin
        bad++; $display("FAIL reset_idle_sclk mode%0d got=%b exp=%b", m, m_sclk[m], (m >= 2));
      end
    end
  endtask

  task automatic test_mode0_loopback();
    logic [7:0] rx; int cs_low, toggles, dones; bit to;
    run0(8'hA5, -1, rx, cs_low, toggles, dones, to);
    total++; if (to) begin bad++; $display("FAIL mode0_timeout got=no_done exp=done"); end
    total++; if (rx !== 8'hA5) begin bad++; $display("FAIL mode0_rx got=%h exp=a5", rx); end
    total++; if (cs_low != 68) begin bad++; $display("FAIL mode0_cs_low got=%0d exp=68", cs_low); end
    total++; if (toggles != 16) begin bad++; $display("FAIL mode0_toggles got=%0d exp=16", toggles); end
    total++; if (dones != 1) begin bad++; $display("FAIL mode0_done_count got=%0d exp=1", dones); end
    total++; if (bus0.o_sclk !== 1'b0) begin bad++; $display("FAIL mode0_idle_sclk got=%b exp=0", bus0.o_sclk); end
    total++; if (bus0.o_busy !== 1'b0) begin bad++; $display("FAIL mode0_idle_busy got=%b exp=0", bus0.o_busy); end
    total++; if (bus0.o_mosi !== 1'b0) begin bad++; $display("FAIL mode0_idle_mosi got=%b exp=0", bus0.o_mosi); end
  endtask

  task automatic test_start_ignored();
    logic [7:0] rx; int cs_low, toggles, dones; bit to;
    run0(8'h5A, 20, rx, cs_low, toggles, dones, to);
    total++; if (to) begin bad++; $display("FAIL ignore_timeout got=no_done exp=done"); end
    total++; if (rx !== 8'h5A) begin bad++; $display("FAIL ignore_rx got=%h exp=5a", rx); end
    total++; if (dones != 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
    total++; if (cs_low != 68) begin bad++; $display("FAIL ignore_cs_low got=%0d exp=68", cs_low); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rx1, rx2; int dones, gap;
    rx1 = 8'h00; rx2 = 8'h00; dones = 0; gap = 0;
    @(negedge clk);
    bus0.i_tx_data = 8'h96;
    bus0.i_start   = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (bus0.o_done) begin
        dones++;
        if (dones == 1) begin
          rx1 = bus0.o_rx_data;
          bus0.i_tx_data = 8'h69;
        end else begin
          rx2 = bus0.o_rx_data;
        end
      end
      if (dones == 1 && bus0.o_cs_n) gap++;
      if (dones == 1 && !bus0.o_cs_n) bus0.i_start = 1'b0;
      if (dones == 2) break;
    end
    bus0.i_start = 1'b0;
    total++; if (dones != 2) begin bad++; $display("FAIL b2b_done_count got=%0d exp=2", dones); end
    total++; if (rx1 !== 8'h96) begin bad++; $display("FAIL b2b_rx1 got=%h exp=96", rx1); end
    total++; if (rx2 !== 8'h69) begin bad++; $display("FAIL b2b_rx2 got=%h exp=69", rx2); end
    total++; if (gap != 1) begin bad++; $display("FAIL b2b_cs_gap got=%0d exp=1", gap); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx; int cs_low, toggles, dones, stray; bit to;
    @(negedge clk);
    bus0.i_tx_data = 8'h3C;
    bus0.i_start   = 1'b1;
    @(negedge clk);
    bus0.i_start = 1'b0;
    repeat (29) @(negedge clk);
    rst0_n = 1'b0;
    #1;
    total++; if (bus0.o_cs_n !== 1'b1) begin bad++; $display("FAIL rst_mid_cs_n got=%b exp=1", bus0.o_cs_n); end
    total++; if (bus0.o_sclk !== 1'b0) begin bad++; $display("FAIL rst_mid_sclk got=%b exp=0", bus0.o_sclk); end
    total++; if (bus0.o_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", bus0.o_busy); end
    total++; if (bus0.o_rx_data !== 8'h00) begin bad++; $display("FAIL rst_mid_rx got=%h exp=00", bus0.o_rx_data); end
    total++; if (bus0.o_mosi !== 1'b0) begin bad++; $display("FAIL rst_mid_mosi got=%b exp=0", bus0.o_mosi); end
    total++; if (state0 !== IDLE) begin bad++; $display("FAIL rst_mid_state got=%0d exp=%0d", state0, IDLE); end
    @(negedge clk);
    rst0_n = 1'b1;
    stray = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (bus0.o_done || !bus0.o_cs_n) stray++;
    end
    total++; if (stray != 0) begin bad++; $display("FAIL rst_mid_stray_activity got=%0d exp=0", stray); end
    run0(8'hE7, -1, rx, cs_low, toggles, dones, to);
    total++; if (to || rx !== 8'hE7) begin bad++; $display("FAIL rst_mid_next_rx got=%h exp=e7", rx); end
    total++; if (dones != 1) begin bad++; $display("FAIL rst_mid_next_done got=%0d exp=1", dones); end
  endtask

  task automatic test_modes();
    logic [7:0] rx, rec; logic pol; bit seen;
    for (int m = 1; m <= 3; m++) begin
      pol = (m >= 2) ? 1'b1 : 1'b0;
      seen = 1'b0; rx = 8'h00; rec = 8'h00;
      @(negedge clk);
      m_tx[m]    = 8'hC3;
      m_start[m] = 1'b1;
      @(negedge clk);
      m_start[m] = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        @(negedge clk);
        if (m_done[m]) begin
          seen = 1'b1;
          rx   = m_rx[m];
          rec  = m_rec[m];
          break;
        end
      end
      @(negedge clk);
      total++; if (!seen) begin bad++; $display("FAIL mode%0d_timeout got=no_done exp=done", m); end
      total++; if (rx !== 8'h3C) begin bad++; $display("FAIL mode%0d_rx got=%h exp=3c", m, rx); end
      total++; if (rec !== 8'hC3) begin bad++; $display("FAIL mode%0d_mosi_stream got=%h exp=c3", m, rec); end
      total++; if (m_sclk[m] !== pol) begin bad++; $display("FAIL mode%0d_idle_sclk got=%b exp=%b", m, m_sclk[m], pol); end
      total++; if (m_cs_n[m] !== 1'b1 || m_busy[m] !== 1'b0) begin
        bad++; $display("FAIL mode%0d_idle_cs_busy got=%b%b exp=10", m, m_cs_n[m], m_busy[m]);
      end
      total++; if (m_state[m] !== IDLE) begin bad++; $display("FAIL mode%0d_state got=%0d exp=%0d", m, m_state[m], IDLE); end
    end
  endtask

  task automatic test_wide();
    logic [15:0] rx; int cs_low, dones, after; bit to;
    rx = 16'h0000; cs_low = 0; dones = 0; after = 0; to = 1'b1;
    @(negedge clk);
    bus4.i_tx_data = 16'h8001;
    bus4.i_start   = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (cyc == 0) bus4.i_start = 1'b0;
      if (!bus4.o_cs_n) cs_low++;
      if (bus4.o_done) begin
        dones++;
        rx = bus4.o_rx_data;
      end
      if (dones > 0) begin
        after++;
        if (after > 4) begin
          to = 1'b0;
          break;
        end
      end
    end
    total++; if (to) begin bad++; $display("FAIL wide_timeout got=no_done exp=done"); end
    total++; if (rx !== 16'h8001) begin bad++; $display("FAIL wide_rx got=%h exp=8001", rx); end
    total++; if (cs_low != 68) begin bad++; $display("FAIL wide_cs_low got=%0d exp=68", cs_low); end
    total++; if (dones != 1) begin bad++; $display("FAIL wide_done_count got=%0d exp=1", dones); end
    total++; if (bus4.o_sclk !== 1'b0 || bus4.o_busy !== 1'b0 || state4 !== IDLE) begin
      bad++; $display("FAIL wide_idle got=sclk%b busy%b state%0d exp=sclk0 busy0 state0", bus4.o_sclk, bus4.o_busy, state4);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst0_n = 1'b0;
    rstm_n = 1'b0;
    bus0.i_start   = 1'b0;
    bus0.i_tx_data = 8'h00;
    bus4.i_start   = 1'b0;
    bus4.i_tx_data = 16'h0000;
    for (int m = 1; m <= 3; m++) begin
      m_start[m] = 1'b0;
      m_tx[m]    = 8'h00;
    end
    repeat (3) @(negedge clk);
    rst0_n = 1'b1;
    rstm_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_mode0_loopback();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_modes();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
